// File: rtl/mod_exp_engine.sv
// mod_exp_engine: left-to-right square-and-multiply base^exp mod 2**M+1, one modular op per clock.
// Define MOD_EXP_EARLY_TERM_EN to start the exponent scan at its highest set bit.
module mod_exp_engine #(
    parameter int WIDTH = 18,
    parameter int M     = 16,
    parameter int PRIME = 65537,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int IW = $clog2(EXP_W);
    localparam int PW = 2 * WIDTH;
    localparam int TW = PW - M + 2;
    localparam logic signed [TW-1:0] PS = TW'(PRIME);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, res_q, res_d, prod_f;
    logic [EXP_W-1:0] e_q, e_d;
    logic [IW-1:0]    idx_q, idx_d, first_idx;
    logic [PW-1:0]    prod;

    // Fermat fold: 2**M == -1, so x = lo + hi*2**M reduces to lo - hi.
    function automatic logic [WIDTH-1:0] fold(input logic [PW-1:0] x);
        logic signed [TW-1:0] t;
        t = $signed({{(TW-M){1'b0}}, x[M-1:0]}) - $signed({2'b00, x[PW-1:M]});
        if (t[TW-1]) t = t + PS;
        else if (t >= PS) t = t - PS;
        return t[WIDTH-1:0];
    endfunction

`ifdef MOD_EXP_EARLY_TERM_EN
    always_comb begin
        first_idx = '0;
        for (int i = 0; i < EXP_W; i++)
            if (exp[i]) first_idx = IW'(i);
    end
`else
    assign first_idx = IW'(EXP_W - 1);
`endif

    assign prod   = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, (state_q == SQR) ? acc_q : b_q};
    assign prod_f = fold(prod);
    assign busy   = (state_q == SQR) || (state_q == MUL);
    assign done   = (state_q == DONE);
    assign result = res_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        e_d     = e_q;
        idx_d   = idx_q;
        res_d   = res_q;
        if (!busy && start) begin
            b_d     = fold({{WIDTH{1'b0}}, base});
            e_d     = exp;
            acc_d   = WIDTH'(1);
            idx_d   = first_idx;
            state_d = (exp == '0) ? DONE : SQR;
            if (exp == '0) res_d = WIDTH'(1);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (busy) begin
            acc_d = prod_f;
            if (state_q == SQR && e_q[idx_q]) begin
                state_d = MUL;
            end else if (idx_q == '0) begin
                state_d = DONE;
                res_d   = prod_f;
            end else begin
                state_d = SQR;
                idx_d   = idx_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            e_q     <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: randomized and directed checks of mod_exp_engine against a plain-arithmetic model.
// Honors MOD_EXP_EARLY_TERM_EN for the expected latency.
module tb_mod_exp_engine;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [17:0] base = '0;
    logic [15:0] exp = '0;
    logic        busy, done;
    logic [17:0] result;
    int          total = 0;
    int          bad = 0;

    mod_exp_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic longint model(input longint b, input longint e);
        longint r = 1;
        longint x = b % 65537;
        while (e > 0) begin
            if ((e & 1) != 0) r = (r * x) % 65537;
            x = (x * x) % 65537;
            e = e >> 1;
        end
        return r;
    endfunction

    // Cycles from capture edge to the done cycle (K + 1).
    function automatic int model_lat(input int e);
        int pop = 0;
        int hi = -1;
        if (e == 0) return 1;
        for (int i = 0; i < 16; i++)
            if (e[i]) begin
                pop++;
                hi = i;
            end
`ifdef MOD_EXP_EARLY_TERM_EN
        return hi + 1 + pop + 1;
`else
        return 16 + pop + 1;
`endif
    endfunction

    task automatic do_op(input logic [17:0] b, input logic [15:0] e, output logic [17:0] r, output int lat);
        @(negedge clk);
        base = b;
        exp = e;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        base = 18'($urandom);
        exp = 16'($urandom);
        lat = 0;
        r = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                r = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
        if (result !== 18'd0) begin bad++; $display("FAIL reset_result: got %0d expected 0", result); end
        rst_n = 1;
    endtask

    task automatic test_directed;
        logic [17:0] bs [7] = '{18'd3, 18'd3, 18'd2, 18'd65536, 18'd0, 18'd7, 18'd262143};
        logic [15:0] es [7] = '{16'd65535, 16'd32768, 16'd1, 16'd2, 16'd5, 16'd0, 16'd1};
        logic [17:0] rs [7] = '{18'd21846, 18'd65536, 18'd2, 18'd1, 18'd0, 18'd1, 18'd65532};
        logic [17:0] r;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(bs[i], es[i], r, lat);
            total += 2;
            if (r !== rs[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %0d expected %0d", i, r, rs[i]);
            end
            if (lat != model_lat(int'(es[i]))) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, model_lat(int'(es[i])));
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat = 0;
        logic [17:0] r = 'x;
        @(negedge clk);
        base = 18'd3;
        exp = 16'hFFFF;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                r = result;
                break;
            end
            start = (c == 5);
            if (c == 5) begin
                base = 18'd9;
                exp = 16'd7;
            end
        end
        start = 0;
        total += 2;
        if (r !== 18'd21846) begin bad++; $display("FAIL ignore_result: got %0d expected 21846", r); end
        if (lat != 33) begin bad++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_back_to_back;
        logic [17:0] r;
        int lat;
        do_op(18'd2, 16'd5, r, lat);
        total += 3;
        if (r !== 18'd32) begin bad++; $display("FAIL b2b_first: got %0d expected 32", r); end
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_done: got %0b expected 0", busy); end
        base = 18'd5;
        exp = 16'd3;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        total += 1;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy_rise: got busy=%0b done=%0b expected busy=1 done=0", busy, done);
        end
        lat = 0;
        r = 'x;
        for (int c = 2; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                r = result;
                break;
            end
        end
        total += 2;
        if (r !== 18'd125) begin bad++; $display("FAIL b2b_second: got %0d expected 125", r); end
        if (lat != model_lat(3)) begin bad++; $display("FAIL b2b_latency: got %0d expected %0d", lat, model_lat(3)); end
    endtask

    task automatic test_abort;
        logic [17:0] r;
        int lat;
        int seen = 0;
        @(negedge clk);
        base = 18'd3;
        exp = 16'hFFFF;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b expected 0", done); end
        if (result !== 18'd0) begin bad++; $display("FAIL abort_result: got %0d expected 0", result); end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total += 1;
        if (seen != 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
        do_op(18'd10, 16'd3, r, lat);
        total += 1;
        if (r !== 18'd1000) begin bad++; $display("FAIL abort_recover: got %0d expected 1000", r); end
    endtask

    task automatic test_random;
        logic [17:0] b, r, want;
        logic [15:0] e;
        int lat, sel;
        for (int n = 0; n < 1500; n++) begin
            sel = int'($urandom_range(0, 3));
            b = (sel == 0) ? 18'($urandom_range(65530, 65540)) : 18'($urandom);
            e = (sel == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            want = 18'(model(longint'(b), longint'(e)));
            do_op(b, e, r, lat);
            total += 2;
            if (r !== want) begin
                bad++;
                $display("FAIL random_result: base=%0d exp=%0d got %0d expected %0d", b, e, r, want);
            end
            if (lat != model_lat(int'(e))) begin
                bad++;
                $display("FAIL random_latency: exp=%0d got %0d expected %0d", e, lat, model_lat(int'(e)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
